// File: rtl/fazyrv_spm_pkg.sv
// Shared types for the FazyRV data scratchpad: opcodes, access sizes, FSM states, request payload.
package fazyrv_spm_pkg;

    localparam int unsigned REG_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_LD  = 3'd0,
        OP_ST  = 3'd1,
        OP_SLL = 3'd2,
        OP_SRL = 3'd3,
        OP_SRA = 3'd4,
        OP_ROL = 3'd5,
        OP_ROR = 3'd6,
        OP_RSV = 3'd7
    } spm_op_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } spm_size_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CAPT  = 3'd1,
        S_WAITD = 3'd2,
        S_ROT   = 3'd3,
        S_EMIT  = 3'd4
    } spm_state_e;

    typedef struct packed {
        spm_op_e    op;
        spm_size_e  size;
        logic       sext;
        logic [1:0] adr;
        logic [4:0] shamt;
    } spm_req_t;

    // Absolute register bit position of bit b inside chunk idx.
    function automatic int unsigned bit_pos(input logic [4:0] idx, input int unsigned b,
                                            input int unsigned chunk);
        return 32'(idx) * chunk + b;
    endfunction

endpackage

// File: rtl/fazyrv_spm_dx_if.sv
// Handshake, serial and dmem-side signals of the data scratchpad.
interface fazyrv_spm_dx_if #(
    parameter int unsigned CHUNKSIZE = 2
);
    logic                 start_i;
    logic [2:0]           op_i;
    logic [1:0]           size_i;
    logic                 sext_i;
    logic [1:0]           adr_lsbs_i;
    logic [4:0]           shamt_i;
    logic                 pdin_vld_i;
    logic [31:0]          pdin_i;
    logic [CHUNKSIZE-1:0] ser_i;
    logic [CHUNKSIZE-1:0] ser_o;
    logic                 ser_vld_o;
    logic [31:0]          pdout_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 misalngd_o;

    modport master (
        output start_i, op_i, size_i, sext_i, adr_lsbs_i, shamt_i, pdin_vld_i, pdin_i, ser_i,
        input  ser_o, ser_vld_o, pdout_o, busy_o, done_o, misalngd_o
    );

    modport slave (
        input  start_i, op_i, size_i, sext_i, adr_lsbs_i, shamt_i, pdin_vld_i, pdin_i, ser_i,
        output ser_o, ser_vld_o, pdout_o, busy_o, done_o, misalngd_o
    );
endinterface

// File: rtl/fazyrv_spm_mask.sv
// Per-chunk keep-mask and fill pattern for shift and load-extension results.
module fazyrv_spm_mask
    import fazyrv_spm_pkg::*;
#(
    parameter int unsigned CHUNKSIZE = 2
) (
    input  spm_op_e              op,
    input  spm_size_e            size,
    input  logic                 sext,
    input  logic [4:0]           shamt,
    input  logic                 sign_r,
    input  logic                 ld_msb,
    input  logic [4:0]           idx,
    output logic [CHUNKSIZE-1:0] mask,
    output logic [CHUNKSIZE-1:0] fill
);
    always_comb begin
        mask = '1;
        fill = '0;
        for (int unsigned b = 0; b < CHUNKSIZE; b++) begin
            case (op)
                OP_SLL: mask[b] = bit_pos(idx, b, CHUNKSIZE) >= 32'(shamt);
                OP_SRL: mask[b] = (bit_pos(idx, b, CHUNKSIZE) + 32'(shamt)) < REG_WIDTH;
                OP_SRA: begin
                    mask[b] = (bit_pos(idx, b, CHUNKSIZE) + 32'(shamt)) < REG_WIDTH;
                    fill[b] = sign_r;
                end
                OP_LD: begin
                    case (size)
                        SZ_B:    mask[b] = bit_pos(idx, b, CHUNKSIZE) < 32'd8;
                        SZ_H:    mask[b] = bit_pos(idx, b, CHUNKSIZE) < 32'd16;
                        default: mask[b] = 1'b1;
                    endcase
                    fill[b] = sext & ld_msb;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fazyrv_spm_dx.sv
// FazyRV data scratchpad: load extraction, store alignment and serial shifts.
// Define FAZYRV_SPM_ROT_EN to enable ROL/ROR; otherwise ops 5/6 behave like the reserved op.
module fazyrv_spm_dx
    import fazyrv_spm_pkg::*;
#(
    parameter int unsigned CHUNKSIZE = 2,
    parameter              CONF      = "MIN"
) (
    input  logic           clk_i,
    input  logic           rst_i,
    fazyrv_spm_dx_if.slave bus
);
    localparam int unsigned ICYC      = REG_WIDTH / CHUNKSIZE;
    localparam int unsigned LOG2C     = $clog2(CHUNKSIZE);
    localparam bit          MISAL_CHK = (CONF != "MIN");

    spm_state_e           state, state_nxt;
    spm_req_t             req_in, req_r;
    logic [REG_WIDTH-1:0] reg_r, reg_nxt;
    logic                 sign_r;
    logic [5:0]           cnt;
    logic [4:0]           rc_r, rb_r, k, idx;
    logic [5:0]           rot_len;
    logic                 misal, rsv, capt_last, emit_last, rot_last, ld_msb;
    logic                 done_d, misal_d, vld_d;
    logic                 done_q, misal_q, vld_q;
    logic [CHUNKSIZE-1:0] ser_d, ser_q, chunk_raw, chunk_mask, chunk_fill;

    always_comb begin
        req_in.op    = spm_op_e'(bus.op_i);
        req_in.size  = spm_size_e'(bus.size_i);
        req_in.sext  = bus.sext_i;
        req_in.adr   = bus.adr_lsbs_i;
        req_in.shamt = bus.shamt_i;
`ifndef FAZYRV_SPM_ROT_EN
        if (req_in.op == OP_ROL || req_in.op == OP_ROR) req_in.op = OP_RSV;
`endif
    end

    assign misal = MISAL_CHK && (req_in.op == OP_LD || req_in.op == OP_ST) &&
                   ((req_in.size == SZ_W && req_in.adr != 2'd0) ||
                    (req_in.size == SZ_H && req_in.adr[0]));
    assign rsv   = (req_in.op == OP_RSV);

    // Right-rotate distance that brings the wanted bits into position.
    always_comb begin
        k = 5'd0;
        case (req_r.op)
            OP_LD:          k = {req_r.adr, 3'b000};
            OP_ST:          k = 5'd0 - {req_r.adr, 3'b000};
            OP_SLL:         k = 5'd0 - req_r.shamt;
            OP_SRL, OP_SRA: k = req_r.shamt;
`ifdef FAZYRV_SPM_ROT_EN
            OP_ROL:         k = 5'd0 - req_r.shamt;
            OP_ROR:         k = req_r.shamt;
`endif
            default:        k = 5'd0;
        endcase
    end

    assign rot_len   = 6'(k >> LOG2C) + 6'(k & 5'(CHUNKSIZE - 1));
    assign capt_last = (cnt == 6'(ICYC - 1));
    assign emit_last = (cnt == 6'(ICYC));
    assign rot_last  = ((6'(rc_r) + 6'(rb_r)) == 6'd1);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start_i && !misal && !rsv)
                    state_nxt = (req_in.op == OP_LD) ? S_WAITD : S_CAPT;
            end
            S_CAPT: begin
                if (capt_last) begin
                    if (rot_len != 6'd0)      state_nxt = S_ROT;
                    else if (req_r.op == OP_ST) state_nxt = S_IDLE;
                    else                        state_nxt = S_EMIT;
                end
            end
            S_WAITD: if (bus.pdin_vld_i) state_nxt = (rot_len != 6'd0) ? S_ROT : S_EMIT;
            S_ROT:   if (rot_last) state_nxt = (req_r.op == OP_ST) ? S_IDLE : S_EMIT;
            S_EMIT:  if (emit_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        done_d  = 1'b0;
        misal_d = 1'b0;
        case (state)
            S_IDLE: begin
                done_d  = bus.start_i && (misal || rsv);
                misal_d = bus.start_i && misal;
            end
            S_CAPT:  done_d = capt_last && rot_len == 6'd0 && req_r.op == OP_ST;
            S_ROT:   done_d = rot_last && req_r.op == OP_ST;
            S_EMIT:  done_d = emit_last;
            default: ;
        endcase
        vld_d = (state_nxt == S_EMIT);
        ser_d = vld_d ? ((chunk_raw & chunk_mask) | (chunk_fill & ~chunk_mask)) : '0;
    end

    // Register shifting/rotation; EMIT reads chunks out of a static reg_r.
    always_comb begin
        reg_nxt = reg_r;
        case (state)
            S_CAPT:  reg_nxt = {bus.ser_i, reg_r[REG_WIDTH-1:CHUNKSIZE]};
            S_WAITD: if (bus.pdin_vld_i) reg_nxt = bus.pdin_i;
            S_ROT: begin
                if (rc_r != 5'd0) reg_nxt = {reg_r[CHUNKSIZE-1:0], reg_r[REG_WIDTH-1:CHUNKSIZE]};
                else              reg_nxt = {reg_r[0], reg_r[REG_WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    assign idx       = (state == S_EMIT) ? cnt[4:0] : 5'd0;
    assign chunk_raw = CHUNKSIZE'(reg_nxt >> (32'(idx) * CHUNKSIZE));
    assign ld_msb    = (req_r.size == SZ_B) ? reg_nxt[7] : reg_nxt[15];

    fazyrv_spm_mask #(.CHUNKSIZE(CHUNKSIZE)) u_mask (
        .op    (req_r.op),
        .size  (req_r.size),
        .sext  (req_r.sext),
        .shamt (req_r.shamt),
        .sign_r(sign_r),
        .ld_msb(ld_msb),
        .idx   (idx),
        .mask  (chunk_mask),
        .fill  (chunk_fill)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_r   <= '0;
            reg_r   <= '0;
            sign_r  <= 1'b0;
            cnt     <= '0;
            rc_r    <= '0;
            rb_r    <= '0;
            ser_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            misal_q <= 1'b0;
        end else begin
            reg_r   <= reg_nxt;
            ser_q   <= ser_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            misal_q <= misal_d;
            if (state == S_IDLE && bus.start_i) begin
                req_r <= req_in;
                cnt   <= '0;
            end
            if (state == S_CAPT) begin
                cnt <= cnt + 6'd1;
                if (capt_last) sign_r <= bus.ser_i[CHUNKSIZE-1];
            end
            if (state_nxt == S_ROT && state != S_ROT) begin
                rc_r <= k >> LOG2C;
                rb_r <= k & 5'(CHUNKSIZE - 1);
            end else if (state == S_ROT) begin
                if (rc_r != 5'd0) rc_r <= rc_r - 5'd1;
                else              rb_r <= rb_r - 5'd1;
            end
            if (state_nxt == S_EMIT) cnt <= (state == S_EMIT) ? cnt + 6'd1 : 6'd1;
        end
    end

    assign bus.ser_o      = ser_q;
    assign bus.ser_vld_o  = vld_q;
    assign bus.pdout_o    = reg_r;
    assign bus.busy_o     = (state != S_IDLE);
    assign bus.done_o     = done_q;
    assign bus.misalngd_o = misal_q;
endmodule

// File: tb/tb_fazyrv_spm_dx.sv
// Scoreboard bench for fazyrv_spm_dx (CHUNKSIZE=2), one CONF="CSR" and one CONF="MIN" instance.
module tb_fazyrv_spm_dx;
    localparam int unsigned C    = 2;
    localparam int unsigned ICYC = 32 / C;

    typedef struct packed {
        logic [31:0] word;
        logic [7:0]  lat;
        logic        misal;
        logic [5:0]  nemit;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fazyrv_spm_dx_if #(.CHUNKSIZE(C)) bus();
    fazyrv_spm_dx_if #(.CHUNKSIZE(C)) bus_min();

    fazyrv_spm_dx #(.CHUNKSIZE(C), .CONF("CSR")) u_dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    fazyrv_spm_dx #(.CHUNKSIZE(C), .CONF("MIN")) u_min (.clk_i(clk), .rst_i(rst), .bus(bus_min));

    exp_t        sb_q[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] col;
    int          nem, lat;
    logic        mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] w, input int l, input logic m, input int n);
        exp_t x;
        x.word  = w;
        x.lat   = 8'(l);
        x.misal = m;
        x.nemit = 6'(n);
        sb_q.push_back(x);
    endtask

    task automatic compare_pop(input string tag, input logic [31:0] obs_word);
        exp_t x;
        x = sb_q.pop_front();
        check({tag, "/data"},    obs_word,     x.word);
        check({tag, "/latency"}, 32'(lat),     32'(x.lat));
        check({tag, "/misal"},   32'(mis),     32'(x.misal));
        check({tag, "/emitted"}, 32'(nem),     32'(x.nemit));
    endtask

    // Drive one operation on the CSR instance, collect emitted chunks until done_o.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] size,
                          input logic sext, input logic [1:0] adr, input logic [4:0] shamt,
                          input logic [31:0] operand, input int waitn, input logic [31:0] ew,
                          input int elat, input logic emis, input int enemit);
        push_exp(ew, elat, emis, enemit);
        col = '0; nem = 0; lat = 0; mis = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = op; bus.size_i = size; bus.sext_i = sext;
        bus.adr_lsbs_i = adr; bus.shamt_i = shamt;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int cyc = 1; cyc <= 200 && lat == 0; cyc++) begin
            if (bus.ser_vld_o) begin
                col = {bus.ser_o, col[31:C]};
                nem++;
            end
            if (bus.done_o) begin
                lat = cyc;
                mis = bus.misalngd_o;
            end else begin
                bus.ser_i      = (cyc <= ICYC) ? 2'(operand >> (C * (cyc - 1))) : 2'b00;
                bus.pdin_vld_i = (op == 3'd0) && (cyc == waitn);
                bus.pdin_i     = bus.pdin_vld_i ? operand : 32'h0;
                @(negedge clk);
            end
        end
        bus.pdin_vld_i = 1'b0;
        bus.ser_i      = '0;
        compare_pop(tag, (op == 3'd1) ? bus.pdout_o : col);
    endtask

    initial begin
        rst = 1'b1;
        bus.start_i = 0; bus.op_i = 0; bus.size_i = 0; bus.sext_i = 0; bus.adr_lsbs_i = 0;
        bus.shamt_i = 0; bus.pdin_vld_i = 0; bus.pdin_i = 0; bus.ser_i = 0;
        bus_min.start_i = 0; bus_min.op_i = 0; bus_min.size_i = 0; bus_min.sext_i = 0;
        bus_min.adr_lsbs_i = 0; bus_min.shamt_i = 0; bus_min.pdin_vld_i = 0;
        bus_min.pdin_i = 0; bus_min.ser_i = 0;
        repeat (3) @(negedge clk);
        check("reset/ctl", 32'({bus.ser_o, bus.ser_vld_o, bus.busy_o, bus.done_o, bus.misalngd_o}), 32'h0);
        check("reset/pdout", bus.pdout_o, 32'h0);
        check("reset/min_ctl", 32'({bus_min.ser_vld_o, bus_min.busy_o, bus_min.done_o}), 32'h0);
        rst = 1'b0;

        run_op("sra4",    3'd4, 2'd2, 1'b0, 2'd0, 5'd4,  32'h80000010, 0, 32'hF8000001, 35, 1'b0, 16);
        run_op("sll31",   3'd2, 2'd2, 1'b0, 2'd0, 5'd31, 32'h00000001, 0, 32'h80000000, 34, 1'b0, 16);
        run_op("srl0",    3'd3, 2'd2, 1'b0, 2'd0, 5'd0,  32'hDEADBEEF, 0, 32'hDEADBEEF, 33, 1'b0, 16);
        run_op("lb_sext", 3'd0, 2'd0, 1'b1, 2'd3, 5'd0,  32'h80FF7F7F, 3, 32'hFFFFFF80, 32, 1'b0, 16);
        run_op("lb_zext", 3'd0, 2'd0, 1'b0, 2'd3, 5'd0,  32'h80FF7F7F, 1, 32'h00000080, 30, 1'b0, 16);
        run_op("lh_sext", 3'd0, 2'd1, 1'b1, 2'd2, 5'd0,  32'h80011234, 2, 32'hFFFF8001, 27, 1'b0, 16);
        run_op("lw_al",   3'd0, 2'd2, 1'b0, 2'd0, 5'd0,  32'h12345678, 1, 32'h12345678, 18, 1'b0, 16);
        run_op("sh_a2",   3'd1, 2'd1, 1'b0, 2'd2, 5'd0,  32'h0000BEEF, 0, 32'hBEEF0000, 25, 1'b0, 0);
        run_op("sb_a1",   3'd1, 2'd0, 1'b0, 2'd1, 5'd0,  32'h000000A5, 0, 32'h0000A500, 29, 1'b0, 0);
        run_op("lw_mis",  3'd0, 2'd2, 1'b0, 2'd1, 5'd0,  32'h0,        0, 32'h0,         1, 1'b1, 0);
        run_op("lh_mis",  3'd0, 2'd1, 1'b0, 2'd3, 5'd0,  32'h0,        0, 32'h0,         1, 1'b1, 0);
        run_op("rsv",     3'd7, 2'd2, 1'b0, 2'd0, 5'd3,  32'h0,        0, 32'h0,         1, 1'b0, 0);
`ifdef FAZYRV_SPM_ROT_EN
        run_op("ror1",    3'd6, 2'd2, 1'b0, 2'd0, 5'd1,  32'h00000001, 0, 32'h80000000, 34, 1'b0, 16);
        run_op("rol4",    3'd5, 2'd2, 1'b0, 2'd0, 5'd4,  32'h80000001, 0, 32'h00000018, 47, 1'b0, 16);
`else
        run_op("ror1",    3'd6, 2'd2, 1'b0, 2'd0, 5'd1,  32'h00000001, 0, 32'h0,         1, 1'b0, 0);
        run_op("rol4",    3'd5, 2'd2, 1'b0, 2'd0, 5'd4,  32'h80000001, 0, 32'h0,         1, 1'b0, 0);
`endif

        // Abort a shift in the middle of emission; a start coinciding with reset is dropped.
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'd4; bus.size_i = 2'd2; bus.shamt_i = 5'd4;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int i = 0; i < 60 && !bus.ser_vld_o; i++) begin
            bus.ser_i = 2'b11;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("rst_mid/emitting", 32'(bus.ser_vld_o), 32'h1);
        rst = 1'b1; bus.start_i = 1'b1; bus.op_i = 3'd3;
        @(negedge clk);
        check("rst_mid/ctl", 32'({bus.ser_o, bus.ser_vld_o, bus.busy_o, bus.done_o, bus.misalngd_o}), 32'h0);
        check("rst_mid/pdout", bus.pdout_o, 32'h0);
        rst = 1'b0; bus.start_i = 1'b0; bus.ser_i = '0;
        @(negedge clk);
        check("rst_mid/start_dropped", 32'(bus.busy_o), 32'h0);
        run_op("srl_rst", 3'd3, 2'd2, 1'b0, 2'd0, 5'd4, 32'hF0000000, 0, 32'h0F000000, 35, 1'b0, 16);

        // MIN configuration lets a misaligned word load through.
        push_exp(32'hDDAABBCC, 22, 1'b0, 16);
        col = '0; nem = 0; lat = 0; mis = 1'b0;
        @(negedge clk);
        bus_min.start_i = 1'b1; bus_min.op_i = 3'd0; bus_min.size_i = 2'd2; bus_min.adr_lsbs_i = 2'd1;
        @(negedge clk);
        bus_min.start_i = 1'b0;
        for (int cyc = 1; cyc <= 200 && lat == 0; cyc++) begin
            if (bus_min.ser_vld_o) begin
                col = {bus_min.ser_o, col[31:C]};
                nem++;
            end
            if (bus_min.done_o) begin
                lat = cyc;
                mis = bus_min.misalngd_o;
            end else begin
                bus_min.pdin_vld_i = (cyc == 1);
                bus_min.pdin_i     = (cyc == 1) ? 32'hAABBCCDD : 32'h0;
                @(negedge clk);
            end
        end
        bus_min.pdin_vld_i = 1'b0;
        compare_pop("min_lw_a1", col);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fazyrv_spm_dx.md
# fazyrv_spm_dx

Next-generation data scratchpad for the FazyRV serial datapath. It handles load extraction, store lane alignment, and SLL/SRL/SRA shifts, plus rotates when enabled. Each operation runs under an explicit start/done handshake, a state machine and a synchronous reset. It sits between the serial ALU/regfile chunk stream and the parallel data-memory port, and takes over the existing data-scratchpad role.

## Interface
- CHUNKSIZE, 2, serial chunk width; legal values 1, 2, 4, 8. ICYC = 32/CHUNKSIZE.
- CONF, "MIN", processor configuration; "MIN" disables misalignment detection.
- clk_i  in  1  clock, rising edge; the single clock of the block.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  start an operation; sampled only in IDLE.
- op_i  in  3  operation: 0 LD, 1 ST, 2 SLL, 3 SRL, 4 SRA, 5 ROL, 6 ROR, 7 reserved.
- size_i  in  2  access size: 0 byte, 1 half, 2 word.
- sext_i  in  1  sign-extend loads.
- adr_lsbs_i  in  2  address bits [1:0].
- shamt_i  in  5  shift/rotate amount.
- pdin_vld_i  in  1  dmem read data valid.
- pdin_i  in  32  dmem read data.
- ser_i  in  CHUNKSIZE  serial operand, LSB chunk first.
- ser_o  out  CHUNKSIZE  serial result.
- ser_vld_o  out  1  ser_o valid.
- pdout_o  out  32  aligned store data, equal to reg_r.
- busy_o  out  1  high when state is not IDLE.
- done_o  out  1  one-cycle completion pulse.
- misalngd_o  out  1  misaligned access, pulses together with done_o.

## Operation
- States: IDLE, CAPT, WAITD, ROT, EMIT.
- IDLE + start_i:
  - If op is LD or ST and the access is misaligned, the block pulses done_o and misalngd_o in the next cycle and stays in IDLE. Misaligned means (word and adr≠0) or (half and adr[0]); this check applies only when CONF≠"MIN".
  - LD → WAITD.
  - All other ops → CAPT.
  - Op 7 → done_o pulse only; no other effect.
- CAPT: ICYC cycles. Each cycle, ser_i shifts into reg_r from the top. sign_r takes ser_i[CHUNKSIZE-1] on the last cycle.
- WAITD: waits for pdin_vld_i, then reg_r ← pdin_i.
- ROT: reg_r is rotated right by k bits.
  - k: SRL/SRA/ROR → shamt; SLL/ROL → (32−shamt) mod 32; LD → 8·adr; ST → (32−8·adr) mod 32.
  - The block first performs k>>log2(CHUNKSIZE) chunk-wide rotations, then k mod CHUNKSIZE single-bit rotations, one rotation per cycle.
  - If k=0, ROT is skipped.
- After ROT, ST pulses done_o and returns to IDLE; pdout_o holds until the next start.
- EMIT: ICYC cycles, ser_vld_o=1. Chunk j carries reg_r bits [j·C +: C] with bit masking:
  - SLL: bits < shamt are 0.
  - SRL: bits > 31−shamt are 0.
  - SRA: bits > 31−shamt take sign_r.
  - LD: bits ≥ 8/16 (byte/half) take sext_i ? bit 7/15 : 0.
  - ROL/ROR/LW: no masking.
- After the last EMIT chunk, the next cycle pulses done_o and returns to IDLE.
- start_i outside IDLE is ignored.

## Timing
- Reset values: state IDLE, reg_r=0, sign_r=0; all outputs are 0.
- Shift latency from start_i to done_o: 1 + ICYC + R + ICYC, where R = (k>>log2 C) + (k & (C−1)).
- Load latency: 1 + wait cycles + R + ICYC.
- Store latency: 1 + ICYC + R.
- ser_o is registered-to-output: the first chunk appears in the first EMIT cycle.
- rst_i mid-operation aborts the operation. No done_o is issued, and the state is IDLE in the next cycle.
- start_i asserted in the same cycle as rst_i is dropped.

## Configuration
- FAZYRV_SPM_ROT_EN defined: ROL/ROR execute as specified above.
- Macro undefined: ops 5 and 6 are treated as op 7 (done_o pulse only, ser_vld_o stays low); the rotate-select logic is removed.

## Structure
- Package fazyrv_spm_pkg holds:
  - enum spm_op_e;
  - enum spm_size_e;
  - enum spm_state_e;
  - localparam REG_WIDTH=32.
- Sub-module fazyrv_spm_mask: combinational per-chunk mask/fill generator. Inputs: op, size, sext, shamt, sign_r, chunk index. Output: mask and fill chunk.
- The top level contains the FSM, the cycle and rotate counters, and reg_r.

## Test plan
- C=2, SRA of 0x80000010, shamt 4 → emitted word 0xF8000001; R=2; done_o at cycle 35 after start.
- SLL of 0x00000001, shamt 31 → 0x80000000; R=1 (bit-rotate only).
- LB, sext=1, adr=3, pdin 0x80FF7F7F → 0xFFFFFF80; R=12. Repeat with sext=0 → 0x00000080.
- SH, adr=2, serial 0x0000BEEF → pdout_o=0xBEEF0000; done_o 25 cycles after start.
- CONF="CSR", LW, adr=1 → misalngd_o and done_o one cycle after start; ser_vld_o never high. With CONF="MIN" the access proceeds.
- With FAZYRV_SPM_ROT_EN: ROR of 0x00000001 by 1 → 0x80000000. Without the macro: done_o after 1 cycle, no emission.
- Assert rst_i in mid-EMIT → all outputs 0 in the next cycle; a following SRL of 0xF0000000 by 4 → 0x0F000000.
